// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared widths, constants, FSM states and entry type for the fetch stage
package fetch_unit_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [InstBus-1:0] ZeroWord = 32'h0000_0000;
    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] DROP  = 2'd3;

    // One fetched instruction as handed across the IF/ID boundary
    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
        logic                   taken;
        logic [InstAddrBus-1:0] dest;
    } fetch_entry_t;

    localparam fetch_entry_t EMPTY_ENTRY = '{pc: ZeroWord, inst: ZeroWord, taken: False, dest: ZeroWord};

endpackage

// File: rtl/fetch_skid.sv
// rtl/fetch_skid.sv - one-entry holding register with load, consume and flush
module fetch_skid
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         consume_i,
    input  logic         flush_i,
    input  fetch_entry_t entry_i,
    output logic         valid_o,
    output fetch_entry_t entry_o
);

    logic         valid_q;
    fetch_entry_t entry_q;

    // Flush wins over load so a redirect never leaves a stale instruction parked here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= False;
            entry_q <= EMPTY_ENTRY;
        end else begin
            if (flush_i) begin
                valid_q <= False;
            end else if (load_i) begin
                valid_q <= True;
            end else if (consume_i) begin
                valid_q <= False;
            end
            if (load_i && !flush_i) begin
                entry_q <= entry_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign entry_o = entry_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC owner, single-outstanding instruction fetch with skid-buffered IF/ID output
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [InstAddrBus-1:0] pc_if,
    input  logic                   je,
    input  logic [InstAddrBus-1:0] jdest,
    output logic                   req_valid,
    output logic [InstAddrBus-1:0] req_addr,
    input  logic                   req_ready,
    input  logic                   resp_valid,
    input  logic [InstBus-1:0]     resp_inst,
    input  logic                   ex_redirect,
    input  logic [InstAddrBus-1:0] ex_redirect_pc,
    input  logic                   id_stall,
    output logic                   if_valid,
    output logic [InstAddrBus-1:0] if_pc,
    output logic [InstBus-1:0]     if_inst,
    output logic                   if_pred_taken,
    output logic [InstAddrBus-1:0] if_pred_dest
);

    logic [1:0]             state_q, state_d;
    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic [InstAddrBus-1:0] pend_pc_q, pend_dest_q;
    logic                   pend_taken_q;
    logic                   out_valid_q, out_valid_d;
    fetch_entry_t           out_entry_q, out_entry_d;

    logic [InstAddrBus-1:0] next_pc;
    logic                   handshake;
    logic                   consume;
    logic                   pend_load;
    fetch_entry_t           resp_entry;
    logic                   skid_load, skid_consume, skid_flush, skid_valid;
    fetch_entry_t           skid_entry;

    assign next_pc    = je ? jdest : pc_q + 32'd4;
    assign req_valid  = (state_q == FETCH) && !ex_redirect;
    assign req_addr   = pc_q;
    assign pc_if      = pc_q;
    assign handshake  = req_valid && req_ready;
    assign consume    = out_valid_q && !id_stall;
    assign pend_load  = handshake;
    assign resp_entry = '{pc: pend_pc_q, inst: resp_inst, taken: pend_taken_q, dest: pend_dest_q};

    // Next-state: redirect overrides everything; otherwise walk FETCH -> WAIT -> (HOLD) -> FETCH
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        out_valid_d  = out_valid_q && !consume;
        out_entry_d  = out_entry_q;
        skid_load    = False;
        skid_consume = False;
        skid_flush   = False;
        if (ex_redirect) begin
            pc_d        = ex_redirect_pc;
            out_valid_d = False;
            skid_flush  = True;
            case (state_q)
                WAIT:    state_d = resp_valid ? FETCH : DROP;
                DROP:    state_d = resp_valid ? FETCH : DROP;
                default: state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (handshake) begin
                        pc_d    = next_pc;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (resp_valid) begin
                        if (!out_valid_q || !id_stall) begin
                            out_valid_d = True;
                            out_entry_d = resp_entry;
                            state_d     = FETCH;
                        end else begin
                            skid_load = True;
                            state_d   = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (consume) begin
                        out_valid_d  = skid_valid;
                        out_entry_d  = skid_entry;
                        skid_consume = True;
                        state_d      = FETCH;
                    end
                end
                default: begin
                    if (resp_valid) begin
                        state_d = FETCH;
                    end
                end
            endcase
        end
    end

    // FSM, fetch PC and IF/ID output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            out_valid_q <= False;
            out_entry_q <= EMPTY_ENTRY;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_entry_q <= out_entry_d;
        end
    end

    // Capture the request's PC and prediction so the response can be tagged with them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_pc_q    <= ZeroWord;
            pend_taken_q <= False;
            pend_dest_q  <= ZeroWord;
        end else if (pend_load) begin
            pend_pc_q    <= pc_q;
            pend_taken_q <= je;
            pend_dest_q  <= next_pc;
        end
    end

    fetch_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .load_i    (skid_load),
        .consume_i (skid_consume),
        .flush_i   (skid_flush),
        .entry_i   (resp_entry),
        .valid_o   (skid_valid),
        .entry_o   (skid_entry)
    );

    assign if_valid      = out_valid_q;
    assign if_pc         = out_entry_q.pc;
    assign if_inst       = out_entry_q.inst;
    assign if_pred_taken = out_entry_q.taken;
    assign if_pred_dest  = out_entry_q.dest;

endmodule
